// File: rtl/dmem_sized.sv
// dmem_sized: word-organised data memory with RV32I load/store sizing.
//
// Handles SB/SH/SW and LB/LH/LW/LBU/LHU with little-endian byte lanes,
// sign/zero extension and misalignment faults. Requests use valid/ready
// and responses come back RD_LAT edges after acceptance through a delay
// pipeline. After reset a clear sequencer zeroes the array one word per
// cycle (when CLEAR_ON_RESET=1) before requests are accepted.
//
// Ports:
//   i_clk, i_rst      rising-edge clock, asynchronous active-high reset
//   i_req_valid       request present
//   o_req_ready       request can be accepted this cycle
//   i_req_we          1 = store, 0 = load
//   i_req_funct3      RV32I size/sign code
//   i_req_addr        byte address
//   i_req_wdata       right-aligned store data
//   o_rsp_valid       one-cycle response strobe
//   o_rsp_rdata       extended load data (0 for stores and faults)
//   o_rsp_err         request faulted
//   o_busy            clear sequence in progress
module dmem_sized #(
    parameter int ADDR_W         = 10,
    parameter int RD_LAT         = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);

    localparam int WA    = ADDR_W - 2;
    localparam int DEPTH = 2 ** WA;
    localparam logic [WA-1:0] CNT_ONE  = {{(WA-1){1'b0}}, 1'b1};
    localparam logic [WA-1:0] CNT_LAST = {WA{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    logic [31:0]       r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WA-1:0]     r_clr_cnt;
    logic              r_ready;
    logic              r_busy;
    logic              w_ready_d;
    logic              w_busy_d;

    logic              w_accept;
    logic [WA-1:0]     w_idx;
    logic [1:0]        w_lane;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_err;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_data;
    logic [31:0]       w_ld_data;

    logic [WA-1:0]     w_mem_idx;
    logic [3:0]        w_mem_be;
    logic [31:0]       w_mem_wd;

    logic [RD_LAT-1:0] r_pv;
    logic [31:0]       r_pd [RD_LAT];
    logic [RD_LAT-1:0] r_pe;

    assign w_accept = i_req_valid & r_ready;
    assign w_idx    = i_req_addr[ADDR_W-1:2];
    assign w_lane   = i_req_addr[1:0];
    assign w_word   = r_mem[w_idx];

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: clear runs until the top word has been written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == CNT_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs, decoded from the next state so the registered copies line up
    always_comb begin
        w_ready_d = 1'b0;
        w_busy_d  = 1'b0;
        case (w_state_nxt)
            ST_CLEAR: w_busy_d  = 1'b1;
            ST_RUN:   w_ready_d = 1'b1;
            default: begin
                w_ready_d = 1'b0;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    // Registered ready/busy; both low while reset is held
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_ready_d;
            r_busy  <= w_busy_d;
        end
    end

    // Clear word counter; restarts from 0 on every reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clr_cnt <= {WA{1'b0}};
        end else if (r_state == ST_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + CNT_ONE;
        end else begin
            r_clr_cnt <= {WA{1'b0}};
        end
    end

    // Lane selection for sub-word loads
    always_comb begin
        w_byte = 8'h00;
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (w_lane[1]) begin
            w_half = w_word[31:16];
        end else begin
            w_half = w_word[15:0];
        end
    end

    // Request decode: fault detection, store lanes, extended load data
    always_comb begin
        w_err     = 1'b0;
        w_st_be   = 4'b0000;
        w_st_data = i_req_wdata;
        w_ld_data = 32'h0000_0000;
        if (i_req_we) begin
            case (i_req_funct3)
                3'b000: begin
                    w_st_be   = 4'b0001 << w_lane;
                    w_st_data = {4{i_req_wdata[7:0]}};
                end
                3'b001: begin
                    w_st_data = {2{i_req_wdata[15:0]}};
                    if (w_lane[0]) begin
                        w_err = 1'b1;
                    end else if (w_lane[1]) begin
                        w_st_be = 4'b1100;
                    end else begin
                        w_st_be = 4'b0011;
                    end
                end
                3'b010: begin
                    if (w_lane != 2'b00) begin
                        w_err = 1'b1;
                    end else begin
                        w_st_be = 4'b1111;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            case (i_req_funct3)
                3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
                3'b100: w_ld_data = {24'h00_0000, w_byte};
                3'b001, 3'b101: begin
                    if (w_lane[0]) begin
                        w_err = 1'b1;
                    end else if (i_req_funct3[2]) begin
                        w_ld_data = {16'h0000, w_half};
                    end else begin
                        w_ld_data = {{16{w_half[15]}}, w_half};
                    end
                end
                3'b010: begin
                    if (w_lane != 2'b00) begin
                        w_err = 1'b1;
                    end else begin
                        w_ld_data = w_word;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    // Array write port select: clear sequencer has priority, stores need acceptance
    always_comb begin
        w_mem_idx = w_idx;
        w_mem_wd  = w_st_data;
        w_mem_be  = 4'b0000;
        if (i_rst) begin
            w_mem_be = 4'b0000;
        end else if (r_state == ST_CLEAR) begin
            w_mem_idx = r_clr_cnt;
            w_mem_wd  = 32'h0000_0000;
            w_mem_be  = 4'b1111;
        end else if (w_accept && i_req_we) begin
            w_mem_be = w_st_be;
        end else begin
            w_mem_be = 4'b0000;
        end
    end

    // Byte-lane array write; no reset so contents survive unless cleared
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_mem_be[i]) begin
                r_mem[w_mem_idx][8*i +: 8] <= w_mem_wd[8*i +: 8];
            end
        end
    end

    // Response pipeline: stage 0 captures the read, later stages only delay
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pv <= {RD_LAT{1'b0}};
            r_pe <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                r_pd[i] <= 32'h0000_0000;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pe[0] <= w_accept & w_err;
            if (w_accept && !i_req_we) begin
                r_pd[0] <= w_ld_data;
            end else begin
                r_pd[0] <= 32'h0000_0000;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pe[i] <= r_pe[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign o_req_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_rsp_valid = r_pv[RD_LAT-1];
    assign o_rsp_err   = r_pe[RD_LAT-1];
    assign o_rsp_rdata = r_pd[RD_LAT-1];

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: two instances (RD_LAT=3 and RD_LAT=4) share one
// request stream; each has its own scoreboard queue fed from a byte-level
// reference memory when a request is driven.
module tb_dmem_sized;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;

    logic        ready3, rsp_valid3, rsp_err3, busy3;
    logic [31:0] rsp_rdata3;
    logic        ready4, rsp_valid4, rsp_err4, busy4;
    logic [31:0] rsp_rdata4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    exp_t e3;
    exp_t e4;

    logic [7:0] mb [1024];
    int cyc;
    int total;
    int passed;

    dmem_sized #(.ADDR_W(10), .RD_LAT(3), .CLEAR_ON_RESET(1'b1)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready3),
        .i_req_we(req_we), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid3), .o_rsp_rdata(rsp_rdata3),
        .o_rsp_err(rsp_err3), .o_busy(busy3)
    );

    dmem_sized #(.ADDR_W(10), .RD_LAT(4), .CLEAR_ON_RESET(1'b1)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready4),
        .i_req_we(req_we), .i_req_funct3(req_funct3), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid4), .o_rsp_rdata(rsp_rdata4),
        .o_rsp_err(rsp_err4), .o_busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the RD_LAT=3 instance
    always @(negedge clk) begin
        if (rsp_valid3) begin
            total++;
            if (q3.size() == 0) begin
                $display("FAIL rsp3_unexpected rdata=%h err=%b cyc=%0d required no response",
                         rsp_rdata3, rsp_err3, cyc);
            end else begin
                e3 = q3.pop_front();
                if (rsp_rdata3 !== e3.rdata || rsp_err3 !== e3.err || cyc !== e3.acc + 2) begin
                    $display("FAIL rsp3 rdata=%h err=%b cyc=%0d required rdata=%h err=%b cyc=%0d",
                             rsp_rdata3, rsp_err3, cyc, e3.rdata, e3.err, e3.acc + 2);
                end else begin
                    passed++;
                end
            end
        end
    end

    // Scoreboard for the RD_LAT=4 instance
    always @(negedge clk) begin
        if (rsp_valid4) begin
            total++;
            if (q4.size() == 0) begin
                $display("FAIL rsp4_unexpected rdata=%h err=%b cyc=%0d required no response",
                         rsp_rdata4, rsp_err4, cyc);
            end else begin
                e4 = q4.pop_front();
                if (rsp_rdata4 !== e4.rdata || rsp_err4 !== e4.err || cyc !== e4.acc + 3) begin
                    $display("FAIL rsp4 rdata=%h err=%b cyc=%0d required rdata=%h err=%b cyc=%0d",
                             rsp_rdata4, rsp_err4, cyc, e4.rdata, e4.err, e4.acc + 3);
                end else begin
                    passed++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout cyc=%0d required finish", cyc);
        $fatal(1, "watchdog");
    end

    // Drive one request for one cycle; expected result comes from the byte model
    task automatic issue(input logic we, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd);
        exp_t e;
        logic err;
        logic [31:0] rd;
        int base;
        int hb;
        logic [15:0] h;
        logic [7:0] b;
        base = {22'd0, a[9:2], 2'b00};
        hb   = base + (a[1] ? 2 : 0);
        b    = mb[a];
        h    = {mb[hb+1], mb[hb]};
        err  = 1'b0;
        rd   = 32'h0;
        if (we) begin
            if (f3 == 3'b000) begin
                mb[a] = wd[7:0];
            end else if (f3 == 3'b001 && a[0] == 1'b0) begin
                mb[hb] = wd[7:0];
                mb[hb+1] = wd[15:8];
            end else if (f3 == 3'b010 && a[1:0] == 2'b00) begin
                for (int k = 0; k < 4; k++) mb[base+k] = wd[8*k +: 8];
            end else begin
                err = 1'b1;
            end
        end else begin
            if (f3 == 3'b000) rd = {{24{b[7]}}, b};
            else if (f3 == 3'b100) rd = {24'h0, b};
            else if (f3 == 3'b001 && a[0] == 1'b0) rd = {{16{h[15]}}, h};
            else if (f3 == 3'b101 && a[0] == 1'b0) rd = {16'h0, h};
            else if (f3 == 3'b010 && a[1:0] == 2'b00)
                rd = {mb[base+3], mb[base+2], mb[base+1], mb[base]};
            else err = 1'b1;
        end
        e.rdata = rd;
        e.err   = err;
        e.acc   = cyc + 1;
        q3.push_back(e);
        q4.push_back(e);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q3.size() != 0 || q4.size() != 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        total++;
        if (q3.size() != 0 || q4.size() != 0) begin
            $display("FAIL %s_drain pending3=%0d pending4=%0d required 0", nm, q3.size(), q4.size());
        end else begin
            passed++;
        end
    endtask

    // Called right after rst falls (posedge+1); counts clear edges until ready
    task automatic wait_clear(input string nm);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (ready3) break;
            if (!busy3 || !busy4 || ready4) busy_ok = 1'b0;
        end
        total++;
        if (n !== 256 || ready4 !== 1'b1 || busy3 !== 1'b0) begin
            $display("FAIL %s_clear_len edges=%0d ready4=%b busy=%b required edges=256 ready4=1 busy=0",
                     nm, n, ready4, busy3);
        end else begin
            passed++;
        end
        total++;
        if (!busy_ok) begin
            $display("FAIL %s_clear_busy busy/ready wrong during clear required busy=1 ready=0", nm);
        end else begin
            passed++;
        end
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ready3, busy3, rsp_valid3, rsp_err3, rsp_rdata3} !== 36'h0) begin
            $display("FAIL reset3 ready=%b busy=%b valid=%b err=%b rdata=%h required all 0",
                     ready3, busy3, rsp_valid3, rsp_err3, rsp_rdata3);
        end else begin
            passed++;
        end
        total++;
        if ({ready4, busy4, rsp_valid4, rsp_err4, rsp_rdata4} !== 36'h0) begin
            $display("FAIL reset4 ready=%b busy=%b valid=%b err=%b rdata=%h required all 0",
                     ready4, busy4, rsp_valid4, rsp_err4, rsp_rdata4);
        end else begin
            passed++;
        end
        rst = 1'b0;
        wait_clear("initial");
    endtask

    task automatic test_sized();
        issue(1'b1, 3'b010, 10'h000, 32'h80F1_7F02);
        issue(1'b1, 3'b000, 10'h001, 32'h0000_00AA);
        issue(1'b0, 3'b010, 10'h000, 32'h0);
        issue(1'b0, 3'b000, 10'h003, 32'h0);
        issue(1'b0, 3'b100, 10'h003, 32'h0);
        issue(1'b0, 3'b001, 10'h002, 32'h0);
        issue(1'b0, 3'b101, 10'h000, 32'h0);
        issue(1'b1, 3'b001, 10'h006, 32'hFFFF_8123);
        issue(1'b0, 3'b010, 10'h004, 32'h0);
        issue(1'b0, 3'b000, 10'h001, 32'h0);
        drain("sized");
    endtask

    task automatic test_faults();
        issue(1'b1, 3'b010, 10'h002, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 10'h000, 32'h0);
        issue(1'b0, 3'b001, 10'h005, 32'h0);
        issue(1'b0, 3'b011, 10'h000, 32'h0);
        issue(1'b1, 3'b100, 10'h000, 32'h1111_1111);
        issue(1'b0, 3'b010, 10'h000, 32'h0);
        issue(1'b1, 3'b001, 10'h001, 32'h0000_5555);
        issue(1'b0, 3'b101, 10'h003, 32'h0);
        issue(1'b0, 3'b110, 10'h000, 32'h0);
        issue(1'b0, 3'b111, 10'h004, 32'h0);
        issue(1'b1, 3'b011, 10'h004, 32'h2222_2222);
        issue(1'b0, 3'b010, 10'h006, 32'h0);
        issue(1'b0, 3'b010, 10'h004, 32'h0);
        drain("faults");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, 3'b010, 10'(32'h020 + 4 * i), 32'hA500_0000 + 32'(i * 32'h0101_0101));
        end
        issue(1'b1, 3'b010, 10'h3FC, 32'hC3B2_A190);
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, 3'b010, 10'(32'h020 + 4 * i), 32'h0);
        end
        issue(1'b0, 3'b010, 10'h3FC, 32'h0);
        issue(1'b0, 3'b000, 10'h3FF, 32'h0);
        issue(1'b0, 3'b101, 10'h3FE, 32'h0);
        issue(1'b1, 3'b001, 10'h3FE, 32'h0000_7E7E);
        issue(1'b0, 3'b010, 10'h3FC, 32'h0);
        drain("b2b");
    endtask

    task automatic test_raw();
        issue(1'b1, 3'b010, 10'h010, 32'h1234_5678);
        issue(1'b0, 3'b010, 10'h010, 32'h0);
        issue(1'b1, 3'b000, 10'h012, 32'h0000_00F0);
        issue(1'b0, 3'b100, 10'h012, 32'h0);
        issue(1'b0, 3'b000, 10'h012, 32'h0);
        drain("raw");
    endtask

    task automatic test_reset_midflight();
        issue(1'b0, 3'b010, 10'h020, 32'h0);
        issue(1'b0, 3'b010, 10'h024, 32'h0);
        issue(1'b0, 3'b010, 10'h028, 32'h0);
        #1;
        total++;
        if (rsp_valid3 !== 1'b1) begin
            $display("FAIL midflight_pre valid3=%b required 1", rsp_valid3);
        end else begin
            passed++;
        end
        rst = 1'b1;
        q3.delete();
        q4.delete();
        #1;
        total++;
        if ({rsp_valid3, rsp_valid4} !== 2'b00) begin
            $display("FAIL midflight_drop valid3=%b valid4=%b required 0 0", rsp_valid3, rsp_valid4);
        end else begin
            passed++;
        end
        repeat (6) @(posedge clk);
        #1;
        total++;
        if ({ready3, busy3, ready4, busy4, rsp_valid3, rsp_valid4} !== 6'b0) begin
            $display("FAIL midflight_rst ready3=%b busy3=%b ready4=%b busy4=%b required 0",
                     ready3, busy3, ready4, busy4);
        end else begin
            passed++;
        end
        rst = 1'b0;
        wait_clear("midflight");
        issue(1'b0, 3'b010, 10'h020, 32'h0);
        drain("midflight");
    endtask

    task automatic test_clear();
        for (int w = 0; w < 256; w++) begin
            issue(1'b1, 3'b010, 10'(w * 4), $urandom | 32'h0000_0001);
        end
        issue(1'b0, 3'b010, 10'h3FC, 32'h0);
        drain("fill");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear("restart");
        issue(1'b0, 3'b010, 10'h3FC, 32'h0);
        issue(1'b0, 3'b010, 10'h000, 32'h0);
        issue(1'b0, 3'b010, 10'h190, 32'h0);
        issue(1'b0, 3'b010, 10'h200, 32'h0);
        drain("clear");
    endtask

    initial begin
        cyc        = 0;
        total      = 0;
        passed     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 10'h000;
        req_wdata  = 32'h0;
        for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
        test_reset();
        test_sized();
        test_faults();
        test_back_to_back();
        test_raw();
        test_reset_midflight();
        test_clear();
        repeat (8) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised, word-organised data memory for the RV32I core. It replaces fixed word-only access with RV32I load/store sizing: SB/SH/SW and LB/LH/LW/LBU/LHU, with byte lanes, sign/zero extension and misalignment faulting. Requests use a valid/ready handshake and responses arrive after a configurable pipelined latency. A hardware clear sequencer zeroes the array after reset. The block sits between the core's MEM stage and the data address space.

## Interface
- ADDR_W, 10, byte-address width; array holds 2**(ADDR_W-2) 32-bit words
- RD_LAT, 1, response latency in cycles; legal range 1..4
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the clear, contents retained

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 size/sign code
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  load result, already extended; 0 for stores and faults
- rsp_err  out  1  request faulted (misaligned or illegal funct3)
- busy  out  1  clear sequence in progress

## Operation
- **Reset values:** req_ready=0, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All latency-pipeline valid bits are cleared. Array contents are not touched asynchronously.
- **FSM states:** CLEAR, RUN.
  - Leaving reset enters CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
  - In CLEAR, one word per cycle is written to zero at an incrementing word counter, starting at 0. busy=1 and req_ready=0.
  - After the last word (2**(ADDR_W-2)-1) is written, the FSM goes to RUN.
  - In RUN, req_ready=1 permanently; no back-pressure.
- **Acceptance:** a request is accepted on a clk edge with req_valid && req_ready. Every accepted request, load or store, produces exactly one response. rsp has no ready; the consumer must always take it.
- **Store funct3:** 000 SB, 001 SH, 010 SW. Lanes are selected by addr[1:0], little-endian. For SB, wdata[7:0] goes to lane addr[1:0]. For SH, wdata[15:0] goes to lanes {addr[1],0}+{1,0}.
- **Load funct3:**
  - 000 LB and 100 LBU: sign- or zero-extend the byte at lane addr[1:0].
  - 001 LH and 101 LHU: sign- or zero-extend the half at {addr[1],0}.
  - 010 LW: the word at addr[ADDR_W-1:2].
- **Faults:** any of the following gives rsp_err=1, rsp_rdata=0, and no array write:
  - SH/LH/LHU with addr[0]=1;
  - SW/LW with addr[1:0]!=0;
  - store funct3 outside {000,001,010};
  - load funct3 in {011,110,111}.
- **Wrap-around:** the upper address bits select the word and the lower two bits select the lane, so no access crosses a word boundary. An aligned access at the top word never wraps.
- **Ordering:** responses return in request order. A store's effect is visible to any load accepted on a later edge, including the very next one.
- **Reset mid-operation:** rst asserted at any time clears the pipeline immediately, so in-flight responses are dropped. An interrupted clear restarts from word 0 after rst deasserts.

## Timing
- A request accepted at edge T gives rsp_valid=1 for the cycle following edge T+RD_LAT-1, i.e. RD_LAT edges after acceptance. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are 0 otherwise.
- Throughput is one request per cycle in RUN. Back-to-back requests give back-to-back responses.
- The array write happens at the acceptance edge. The array read also happens at the acceptance edge, registered. Stages 2..RD_LAT are pure delay registers.
- Clear lasts exactly 2**(ADDR_W-2) cycles. With ADDR_W=10, req_ready first reads 1 in the 257th cycle after the first clk edge with rst low (256 clear edges).
- There is no combinational path from req_* to rsp_* or to req_ready.

## Test plan
- **Clear:** fill the array, pulse rst, then poll. Expect busy=1 and req_ready=0 for 256 cycles. Then LW at 0x3FC returns 0x00000000, err=0.
- **Sized stores and loads:**
  - Issue SW 0x0 = 0x80F17F02, then SB 0x1 = 0xAA.
  - LW 0x0 returns 0x80F1AA02.
  - LB 0x3 returns 0xFFFFFF80; LBU 0x3 returns 0x00000080.
  - LH 0x2 returns 0xFFFF80F1; LHU 0x0 returns 0x0000AA02.
- **Faults:**
  - SW at 0x2 gives err=1 and memory unchanged.
  - LH at 0x5 gives err=1, rdata=0.
  - Load funct3=011 gives err=1.
  - Store funct3=100 gives err=1 with no write.
- **Latency and throughput with RD_LAT=3:** issue 8 back-to-back loads on consecutive cycles. Expect 8 consecutive rsp_valid pulses starting 3 edges after the first acceptance, in order, with correct data.
- **Read-after-write:** SW 0x10 = 0x12345678 at edge T, then LW 0x10 at edge T+1. The response returns 0x12345678. The store's own response has rdata=0, err=0.
- **Reset mid-flight:** with RD_LAT=4 and 3 loads in flight, assert rst asynchronously. rsp_valid drops to 0 immediately, no stale responses appear afterwards, and clear restarts from word 0.
